// File: rtl/counter_pkg.sv
// Shared types and constants for the counter family (modulo up-counter, reload down-counter).
package counter_pkg;

  typedef enum logic {CNT_IDLE, CNT_RUN} counter_state_t;

  localparam logic CNT_MODE_PERIODIC = 1'b0;
  localparam logic CNT_MODE_ONESHOT  = 1'b1;

  // Zero-detection implementation codes
  localparam int CNT_IMPL_CMP_CUR = 0;
  localparam int CNT_IMPL_CMP_NXT = 1;

endpackage

// File: rtl/counter_down_reload.sv
// Loadable down-counter with terminal pulse; periodic reload or one-shot stop at zero.
module counter_down_reload
  import counter_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int IMPLEMENTATION = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic             mode,
  input  logic             ena,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] cnt,
  output logic             pls,
  output logic             bsy
);

  counter_state_t   state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CNT_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pls     = 1'b0;
    if (clr) begin
      state_d = CNT_IDLE;
      cnt_d   = '0;
    end else if (ld) begin
      state_d = CNT_RUN;
      cnt_d   = max;
    end else if (state_q == CNT_RUN && ena) begin
      if (zero) begin
        pls = 1'b1;
        if (mode == CNT_MODE_PERIODIC) begin
          cnt_d = max;
        end else begin
          state_d = CNT_IDLE;
          cnt_d   = '0;
        end
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  generate
    case (IMPLEMENTATION)
      CNT_IMPL_CMP_CUR: begin : g_cmp_cur
        assign zero = (cnt_q == '0);
      end
      CNT_IMPL_CMP_NXT: begin : g_cmp_nxt
        // Comparing cnt_d covers every event: clr/stop -> 1, ld/reload -> max==0,
        // decrement -> cnt==1, hold -> unchanged. Keeps the compare off the pls path.
        logic zero_q, zero_d;
        assign zero_d = (cnt_d == '0);
        always_ff @(posedge clk or posedge rst) begin
          if (rst) zero_q <= 1'b1;
          else     zero_q <= zero_d;
        end
        assign zero = zero_q;
      end
      default: begin : g_bad_impl
        $fatal(1, "counter_down_reload: unsupported IMPLEMENTATION %0d", IMPLEMENTATION);
        assign zero = 1'b0;
      end
    endcase
  endgenerate

  assign cnt = cnt_q;
  assign bsy = (state_q == CNT_RUN);

endmodule

// File: tb/tb_counter_down_reload.sv
module tb_counter_down_reload;

  logic        clk = 1'b0;
  logic        rst, clr, ld, mode, ena;
  logic [31:0] max;

  logic [3:0]  cnt_a, cnt_b;
  logic [31:0] cnt_c, cnt_d;
  logic        pls_a, pls_b, pls_c, pls_d;
  logic        bsy_a, bsy_b, bsy_c, bsy_d;

  int checks = 0;
  int errors = 0;

  longint m_cnt4, m_cnt32;
  bit     m_run4, m_run32;

  always #5 clk = ~clk;

  counter_down_reload #(.WIDTH(4), .IMPLEMENTATION(0)) u_w4_i0 (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .mode(mode), .ena(ena),
    .max(max[3:0]), .cnt(cnt_a), .pls(pls_a), .bsy(bsy_a));
  counter_down_reload #(.WIDTH(4), .IMPLEMENTATION(1)) u_w4_i1 (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .mode(mode), .ena(ena),
    .max(max[3:0]), .cnt(cnt_b), .pls(pls_b), .bsy(bsy_b));
  counter_down_reload #(.WIDTH(32), .IMPLEMENTATION(0)) u_w32_i0 (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .mode(mode), .ena(ena),
    .max(max), .cnt(cnt_c), .pls(pls_c), .bsy(bsy_c));
  counter_down_reload #(.WIDTH(32), .IMPLEMENTATION(1)) u_w32_i1 (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .mode(mode), .ena(ena),
    .max(max), .cnt(cnt_d), .pls(pls_d), .bsy(bsy_d));

  logic [135:0] obs;
  assign obs = {28'b0, cnt_a, pls_a, bsy_a, 28'b0, cnt_b, pls_b, bsy_b,
                cnt_c, pls_c, bsy_c, cnt_d, pls_d, bsy_d};

  function automatic logic [135:0] exp_vec();
    logic [33:0] e4, e32;
    logic        p4, p32;
    p4  = m_run4  && ena && (m_cnt4  == 0) && !clr && !ld && !rst;
    p32 = m_run32 && ena && (m_cnt32 == 0) && !clr && !ld && !rst;
    e4  = {m_cnt4[31:0], p4, m_run4};
    e32 = {m_cnt32[31:0], p32, m_run32};
    return {e4, e4, e32, e32};
  endfunction

  function automatic void model_upd(input longint mask, inout longint c, inout bit r);
    if (rst || clr) begin
      r = 0; c = 0;
    end else if (ld) begin
      r = 1; c = max & mask;
    end else if (r && ena) begin
      if (c > 0)      c = c - 1;
      else if (!mode) c = max & mask;
      else            r = 0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_upd(64'hF, m_cnt4, m_run4);
    model_upd(64'hFFFF_FFFF, m_cnt32, m_run32);
    #1;
  endtask

  task automatic set_in(input bit c, input bit l, input bit m, input bit e, input logic [31:0] mx);
    clr = c; ld = l; mode = m; ena = e; max = mx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 1, 32'd7);
    step(); step();
    @(negedge clk);
    checks++;
    if (obs !== {136{1'b0}}) begin
      errors++;
      $display("FAIL reset_state obs=%h exp=%h", obs, {136{1'b0}});
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_periodic();
    int npls = 0;
    set_in(0, 1, 0, 1, 32'd3);
    step();
    ld = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL periodic_c%0d obs=%h exp=%h", i, obs, exp_vec());
      end
      if (pls_b) npls++;
      checks++;
      if (pls_a !== ((i % 4) == 0)) begin
        errors++;
        $display("FAIL periodic_pls_c%0d act=%b req=%b", i, pls_a, (i % 4) == 0);
      end
      step();
    end
    checks++;
    if (npls !== 3) begin
      errors++;
      $display("FAIL periodic_count act=%0d req=3", npls);
    end
  endtask

  task automatic test_oneshot();
    int npls = 0;
    set_in(0, 1, 1, 1, 32'd2);
    step();
    ld = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL oneshot_c%0d obs=%h exp=%h", i, obs, exp_vec());
      end
      if (pls_c) npls++;
      step();
    end
    checks++;
    if (npls !== 1 || bsy_d !== 1'b0 || cnt_d !== 32'd0) begin
      errors++;
      $display("FAIL oneshot_end pls=%0d bsy=%b cnt=%0d req pls=1 bsy=0 cnt=0", npls, bsy_d, cnt_d);
    end
  endtask

  task automatic test_ena_gating();
    int npls = 0;
    int pls_at = -1;
    set_in(0, 1, 0, 0, 32'd5);
    step();
    ld = 0;
    for (int i = 1; i <= 14; i++) begin
      ena = (i % 2 == 1);
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL ena_gating_c%0d obs=%h exp=%h", i, obs, exp_vec());
      end
      if (pls_a) begin npls++; pls_at = i; end
      step();
    end
    checks++;
    if (npls !== 1 || pls_at !== 11) begin
      errors++;
      $display("FAIL ena_gating_pulse count=%0d at=%0d req count=1 at=11", npls, pls_at);
    end
  endtask

  task automatic test_max0();
    set_in(0, 1, 0, 1, 32'd0);
    step();
    ld = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec() || pls_b !== 1'b1) begin
        errors++;
        $display("FAIL max0_periodic_c%0d obs=%h exp=%h", i, obs, exp_vec());
      end
      step();
    end
    set_in(0, 1, 1, 1, 32'd0);
    step();
    ld = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec() || pls_d !== (i == 1)) begin
        errors++;
        $display("FAIL max0_oneshot_c%0d obs=%h exp=%h", i, obs, exp_vec());
      end
      step();
    end
  endtask

  task automatic test_collisions();
    set_in(0, 1, 0, 1, 32'd2);
    step();
    ld = 0;
    step(); step();
    set_in(0, 1, 0, 1, 32'd6);
    @(negedge clk);
    checks++;
    if (obs !== exp_vec() || pls_a !== 1'b0 || cnt_c !== 32'd0) begin
      errors++;
      $display("FAIL ld_at_zero obs=%h exp=%h", obs, exp_vec());
    end
    step();
    ld = 0;
    @(negedge clk);
    checks++;
    if (obs !== exp_vec() || cnt_d !== 32'd6) begin
      errors++;
      $display("FAIL ld_at_zero_cnt obs=%h exp=%h", obs, exp_vec());
    end
    set_in(1, 1, 0, 1, 32'd9);
    step();
    set_in(0, 0, 0, 1, 32'd9);
    @(negedge clk);
    checks++;
    if (obs !== {136{1'b0}}) begin
      errors++;
      $display("FAIL clr_with_ld obs=%h exp=%h", obs, {136{1'b0}});
    end
    set_in(0, 1, 0, 1, 32'd9);
    step();
    ld = 0;
    step(); step();
    @(negedge clk);
    checks++;
    if (cnt_b !== 4'd7 || cnt_c !== 32'd7) begin
      errors++;
      $display("FAIL pre_rst_cnt act=%0d req=7", cnt_c);
    end
    #2 rst = 1'b1;
    #1;
    m_cnt4 = 0; m_cnt32 = 0; m_run4 = 0; m_run32 = 0;
    checks++;
    if (obs !== {136{1'b0}}) begin
      errors++;
      $display("FAIL async_rst obs=%h exp=%h", obs, {136{1'b0}});
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_range();
    set_in(0, 1, 0, 1, 32'd15);
    step();
    ld = 0;
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec() || pls_b !== (i % 16 == 0)) begin
        errors++;
        $display("FAIL full_range_c%0d obs=%h exp=%h", i, obs, exp_vec());
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clr  = ($urandom_range(99) < 3);
      ld   = ($urandom_range(99) < 6);
      ena  = ($urandom_range(99) < 75);
      mode = $urandom_range(1);
      max  = ($urandom_range(1) == 1) ? 32'($urandom_range(15)) : $urandom;
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random_c%0d obs=%h exp=%h", i, obs, exp_vec());
      end
      step();
    end
  endtask

  initial begin
    m_cnt4 = 0; m_cnt32 = 0; m_run4 = 0; m_run32 = 0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_ena_gating();
    test_max0();
    test_collisions();
    test_full_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_down_reload.md
Name: counter_down_reload

Overview:
- Loadable down-counter: the decrementing counterpart of the team's modulo up-counter.
- Loads a reload value, counts down to zero on enabled cycles, and emits a one-cycle pulse when zero is consumed.
- Zero handling depends on mode: periodic mode reloads; one-shot mode stops.
- Used as a programmable timer/prescaler, e.g. baud ticks, timeouts, frame counters.

Parameters:
- WIDTH, 32, counter and reload value width in bits (>=1).
- IMPLEMENTATION, 0, zero detection: 0 = compare current (combinational cnt=='0); 1 = compare next (registered zero flag computed from next value). Any other value is an elaboration $fatal.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- clr  input  1  synchronous abort to IDLE
- ld   input  1  load reload value and start
- mode  input  1  0 = periodic reload, 1 = one-shot
- ena  input  1  count enable (tick)
- max  input  WIDTH  reload value; period = max+1 enabled cycles
- cnt  output  WIDTH  current count
- pls  output  1  terminal pulse (zero consumed)
- bsy  output  1  high while in RUN

Behaviour:
- Reset (async, rst=1): state IDLE, cnt=0, zero flag=1, bsy=0, pls=0.
- States: IDLE and RUN. bsy = (state==RUN), registered via state.
- Priority each cycle: clr > ld > count.
- clr=1: state <= IDLE, cnt <= 0. pls=0 that cycle.
- ld=1 (clr=0), from any state:
  - cnt <= max, state <= RUN.
  - ena is ignored that cycle; pls=0.
  - mode is sampled every cycle, not latched.
- RUN, ena=1, no clr/ld:
  - cnt!=0: cnt <= cnt-1.
  - cnt==0: pls=1. If mode=0, cnt <= max (uses current max). If mode=1, state <= IDLE and cnt stays 0.
- RUN, ena=0: hold. pls=0.
- IDLE: cnt holds 0. ena has no effect. pls=0.
- pls is combinational: RUN & ena & zero & ~clr & ~ld. No latency from ena to pls.
- Period check: max=N in periodic mode with ena=1 continuously gives pls every N+1 cycles. Pulses happen on the cycle cnt==0.
- max=0: periodic gives pls on every enabled cycle; one-shot gives pls on the first enabled cycle after ld.
- Wrap-around: the decrement never underflows, because zero always reloads or stops. No borrow past 0.
- IMPLEMENTATION 1: zero-flag register updates as follows, and must be cycle-identical to IMPLEMENTATION 0:
  - on ld/reload: <= (max=='0)
  - on decrement: <= (cnt==1)
  - on clr: <= 1
- Reset mid-count: immediate IDLE/0. No pulse is emitted.
- ld on the same cycle cnt==0 & ena: load wins. No pulse.

Decomposition:
- Package counter_pkg:
  - typedef enum logic {CNT_IDLE, CNT_RUN} counter_state_t
  - localparams CNT_MODE_PERIODIC=1'b0, CNT_MODE_ONESHOT=1'b1
  - IMPLEMENTATION code constants, shared with counter_modulo.
- Single module, no sub-module. Implementation selection uses a generate case, same structure as counter_modulo.

Test Plan:
- Reset then ld=1, max=3, mode=0, ena=1 continuous -> cnt 3,2,1,0,3,...; pls on cycles 4, 8, 12 after ld; bsy=1.
- One-shot: max=2, mode=1, ena=1 -> cnt 2,1,0; pls once; then bsy=0, cnt=0; further ena gives no pls.
- ena gating: max=5, ena toggling 1/0 -> pls exactly after 6 enabled cycles; cnt holds while ena=0.
- max=0 periodic -> pls every enabled cycle. max=0 one-shot -> single pls, then IDLE.
- Collisions:
  - ld on the cnt==0 cycle -> no pls, cnt=max.
  - clr together with ld -> IDLE, cnt=0.
  - rst asserted mid-count (cnt=7) -> async cnt=0, bsy=0, pls=0.
- Run all above for IMPLEMENTATION 0 and 1 with WIDTH=4 and 32, comparing cycle-by-cycle. Compare also at max=15 with WIDTH=4 (full range, period 16). Outputs must be identical.
